// File: rtl/sqr_serial.sv
// Iterative radix-2 shift-add squarer: sq = root*root, one multiplier bit per cycle.
// Optional SQR_REM_EN adds a remainder to rebuild the radicand and flags rem > 2*root on err.
module sqr_serial #(
  parameter  int Q_WIDTH = 16,
  localparam int D_WIDTH = 2 * Q_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [Q_WIDTH-1:0] root,
  input  logic [Q_WIDTH:0]   rem,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [D_WIDTH-1:0] sq,
  output logic               err
);

  localparam int CNT_W = (Q_WIDTH > 1) ? $clog2(Q_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [Q_WIDTH-1:0] mcand;
  logic [Q_WIDTH-1:0] mult;
  logic [D_WIDTH-1:0] acc;
  logic [D_WIDTH-1:0] acc_next;
  logic [CNT_W-1:0]   cnt;
  logic [D_WIDTH-1:0] result;

  // MSB-first: doubling the partial sum before each add weights earlier bits correctly.
  always_comb begin
    acc_next = (acc << 1) + (mult[Q_WIDTH-1] ? D_WIDTH'(mcand) : '0);
  end

`ifdef SQR_REM_EN
  logic [Q_WIDTH:0] rem_q;
  logic             err_q;
  logic             rem_bad;

  // Largest legal remainder is 2*root, so anything above it means a bad pair.
  assign rem_bad = rem_q > {mcand, 1'b0};
  assign result  = acc_next + D_WIDTH'(rem_q);
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && in_vld && in_rdy)
        rem_q <= rem;
      if (state == BUSY && cnt == '0)
        err_q <= rem_bad;
      else if (state == DONE && out_vld && out_rdy)
        err_q <= 1'b0;
    end
  end
`else
  logic unused_rem;

  assign unused_rem = ^rem;
  assign result     = acc_next;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      in_rdy  <= 1'b1;
      out_vld <= 1'b0;
      sq      <= '0;
      mcand   <= '0;
      mult    <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_vld && in_rdy) begin
            mcand  <= root;
            mult   <= root;
            acc    <= '0;
            cnt    <= CNT_W'(Q_WIDTH - 1);
            state  <= BUSY;
            in_rdy <= 1'b0;
          end
        end
        BUSY: begin
          acc  <= acc_next;
          mult <= mult << 1;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            sq      <= result;
            out_vld <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          // sq is left holding the result after the handshake.
          if (out_vld && out_rdy) begin
            out_vld <= 1'b0;
            in_rdy  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          in_rdy  <= 1'b1;
          out_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule
